color_manager_sync_gen: RTL
===========================

# color_manager_sync_gen

Programmable raster timing generator for the Color Manager, on the driving side of the line-sync interface. It produces active-low HSync and VSync, the per-line `Sync` enable, and the `BackPorch`/`FrontPorch` window bounds that the Color Manager pixel counter consumes. Per line, the generator owns the horizontal and vertical state machines. A downstream counter that sees `Sync` high counts exactly the active pixels.

## Interface
- `H_WIDTH`, 12: width of horizontal length config inputs and internal horizontal counter.
- `V_WIDTH`, 11: width of vertical length config inputs, line counter and `Line`.
- `BACKPORCH_WIDTH`, 12: width of `BackPorch` output.
- `FRONTPORCH_WIDTH`, 12: width of `FrontPorch` output.

Ports:
- `Clk`  in  1  sole clock, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `En`  in  1  run enable.
- `H_Sync_Len`, `H_Back_Len`, `H_Active_Len`, `H_Front_Len`  in  H_WIDTH each  horizontal segment lengths in cycles.
- `V_Sync_Len`, `V_Back_Len`, `V_Active_Len`, `V_Front_Len`  in  V_WIDTH each  vertical segment lengths in lines.
- `HSync`  out  1  horizontal sync, active low.
- `VSync`  out  1  vertical sync, active low.
- `Sync`  out  1  line enable to the pixel counter.
- `BackPorch`  out  BACKPORCH_WIDTH  latched `H_Back_Len - 1`.
- `FrontPorch`  out  FRONTPORCH_WIDTH  latched `H_Back_Len + H_Active_Len`.
- `Line`  out  V_WIDTH  active-line index.
- `Frame_Start`  out  1  one-cycle pulse on the first cycle of each frame.
- `Busy`  out  1  generator running.

## Operation
- **Config latching.** All eight length inputs are latched into shadow registers on the cycle a frame starts. Changes mid-frame have no effect until the next frame.
- **Zero lengths.** A latched length of 0 is clamped to 1.
- **Horizontal FSM (states `H_SYNC`, `H_LINE`).** Line position k runs 0..T-1, where T = hs + hbp + hact + hfp.
  - k < hs: `H_SYNC`, `HSync`=0.
  - Otherwise: `H_LINE`, `HSync`=1.
  - At k = T-1, k wraps to 0 and the line counter advances.
- **Vertical FSM (states `V_SYNC`, `V_BACK`, `V_ACTIVE`, `V_FRONT`).** The state advances only at line wrap.
  - Lines spent in each state: vs, vbp, vact, vfp respectively.
  - `VSync`=0 in `V_SYNC`.
  - After the last `V_FRONT` line, the generator returns to `V_SYNC` and starts a new frame (re-latching config).
- **Sync.** `Sync`=1 iff state is `H_LINE` and `V_ACTIVE`, giving hbp + hact + hfp consecutive cycles per active line. A downstream counter whose internal count starts at 0 on the first `Sync`=1 cycle and that counts strictly between `BackPorch` and `FrontPorch` covers exactly internal counts hbp..hbp+hact-1.
- **BackPorch / FrontPorch.** Driven from the latched values and updated only at frame start.
  - Arithmetic is done at max(H_WIDTH, FRONTPORCH_WIDTH)+1 bits, then truncated to the output width.
  - Overflow is a configuration error. No clamping is applied.
- **Line.** Holds the index 0..vact-1 during `V_ACTIVE`, updating at line start. It is 0 in all other vertical states.
- **Idle.** When `En`=0 in idle, all outputs are held at reset values.
- **Start.** When `En`=1 in idle, the next cycle is frame cycle 0 (k=0, `V_SYNC`).
- **Stop.** If `En` drops while running, the current frame completes. The generator then goes idle at the frame boundary instead of restarting.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Reset values: `HSync`=1, `VSync`=1, `Sync`=0, `BackPorch`=0, `FrontPorch`=0, `Line`=0, `Frame_Start`=0, `Busy`=0. Internal counters and FSMs go to idle.
- `Rst` mid-frame: the reset values above appear on the cycle after the `Rst` edge, and the partial frame is abandoned.
- Start latency: if `En` rises at edge N, then at edge N+1 `Busy`=1, `Frame_Start`=1, `HSync`=0, `VSync`=0, and `BackPorch`/`FrontPorch` take the new values.
- `Frame_Start` is high only on frame cycle 0.
- `HSync` and `VSync` fall on the same cycle at each frame start. `VSync` edges always coincide with k=0.
- If `En`=0 at the last cycle of a frame, the next cycle is idle with reset-valued outputs and `Busy`=0.

## Test plan
- **Basic frame.** Config hs=2, hbp=3, hact=4, hfp=2, vs=1, vbp=1, vact=2, vfp=1; `En`=1 held.
  - Expect line period 11 and frame period 55 cycles.
  - Expect `HSync` low for 2 cycles per line, `VSync` low for cycles 0..10.
  - Expect `Sync` high for 9 cycles in lines 2 and 3 only, with `Line`=0 then 1.
  - Expect `BackPorch`=2, `FrontPorch`=7, and `Frame_Start` every 55 cycles.
- **Loopback with pixel counter.** Same config, outputs fed to the Color Manager counter. Expect exactly 4 valid cycles per active line, counter values 1..4, and 8 per frame.
- **Mid-frame config change.** Change hact to 6 at frame cycle 20. Expect the current frame unchanged. Next frame has period 13×5=65, `FrontPorch`=9.
- **Zero clamp.** hs=0, vfp=0. Expect 1-cycle `HSync` pulse and 1 front-porch line.
- **Enable handling.** Drop `En` mid-frame. Expect the frame to finish at cycle 54, then `Busy`=0 and outputs at reset values. Re-raise `En`: expect `Frame_Start` one cycle later.
- **Reset mid-frame.** `Rst`=1 at cycle 30. Expect all outputs at reset values the next cycle. Release with `En`=1: expect a clean frame from cycle 0.

Source files
------------

// File: rtl/color_manager_sync_gen.sv
// Raster timing generator for the Color Manager: HSync/VSync, the per-line Sync
// enable and the BackPorch/FrontPorch window bounds for the downstream pixel counter.
//
// state    | meaning
// H_SYNC   | line position k below the latched hsync length, HSync low
// H_LINE   | rest of the line (back porch, active, front porch)
// V_SYNC   | vertical sync lines, VSync low
// V_BACK   | vertical back-porch lines
// V_ACTIVE | active lines, Sync follows H_LINE, Line holds the index
// V_FRONT  | vertical front-porch lines; the last one closes the frame
module color_manager_sync_gen #(
  parameter int H_WIDTH          = 12,
  parameter int V_WIDTH          = 11,
  parameter int BACKPORCH_WIDTH  = 12,
  parameter int FRONTPORCH_WIDTH = 12
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        En,
  input  logic [H_WIDTH-1:0]          H_Sync_Len,
  input  logic [H_WIDTH-1:0]          H_Back_Len,
  input  logic [H_WIDTH-1:0]          H_Active_Len,
  input  logic [H_WIDTH-1:0]          H_Front_Len,
  input  logic [V_WIDTH-1:0]          V_Sync_Len,
  input  logic [V_WIDTH-1:0]          V_Back_Len,
  input  logic [V_WIDTH-1:0]          V_Active_Len,
  input  logic [V_WIDTH-1:0]          V_Front_Len,
  output logic                        HSync,
  output logic                        VSync,
  output logic                        Sync,
  output logic [BACKPORCH_WIDTH-1:0]  BackPorch,
  output logic [FRONTPORCH_WIDTH-1:0] FrontPorch,
  output logic [V_WIDTH-1:0]          Line,
  output logic                        Frame_Start,
  output logic                        Busy
);

  localparam logic [0:0] H_SYNC   = 1'b0;
  localparam logic [0:0] H_LINE   = 1'b1;
  localparam logic [1:0] V_SYNC   = 2'd0;
  localparam logic [1:0] V_BACK   = 2'd1;
  localparam logic [1:0] V_ACTIVE = 2'd2;
  localparam logic [1:0] V_FRONT  = 2'd3;

  // The line position must hold the sum of four segment lengths, hence two extra bits.
  localparam int KW = H_WIDTH + 2;
  localparam int AW = ((H_WIDTH > FRONTPORCH_WIDTH) ? H_WIDTH : FRONTPORCH_WIDTH) + 1;

  function automatic logic [H_WIDTH-1:0] clamp_h(input logic [H_WIDTH-1:0] x);
    return (x == '0) ? H_WIDTH'(1) : x;
  endfunction

  function automatic logic [V_WIDTH-1:0] clamp_v(input logic [V_WIDTH-1:0] x);
    return (x == '0) ? V_WIDTH'(1) : x;
  endfunction

  logic               busy_q, nxt_busy;
  logic [KW-1:0]      k_q, nxt_k;
  logic [1:0]         v_q, nxt_v;
  logic [V_WIDTH-1:0] vcnt_q, nxt_vcnt;
  logic [H_WIDTH-1:0] hs_q, hbp_q, hact_q, hfp_q;
  logic [H_WIDTH-1:0] nxt_hs, nxt_hbp, nxt_hact, nxt_hfp;
  logic [V_WIDTH-1:0] vs_q, vbp_q, vact_q, vfp_q;
  logic [V_WIDTH-1:0] nxt_vs, nxt_vbp, nxt_vact, nxt_vfp;

  logic [KW-1:0]      t_len;
  logic [V_WIDTH-1:0] v_len;
  logic               line_end, v_last, frame_end, start;
  logic [0:0]         nxt_h;
  logic [AW-1:0]      bp_full, fp_full;

  always_comb begin
    t_len = KW'(hs_q) + KW'(hbp_q) + KW'(hact_q) + KW'(hfp_q);
    unique case (v_q)
      V_SYNC:   v_len = vs_q;
      V_BACK:   v_len = vbp_q;
      V_ACTIVE: v_len = vact_q;
      default:  v_len = vfp_q;
    endcase
  end

  assign line_end  = (k_q == t_len - KW'(1));
  assign v_last    = (vcnt_q == v_len - V_WIDTH'(1));
  assign frame_end = busy_q && line_end && (v_q == V_FRONT) && v_last;
  assign start     = En && (!busy_q || frame_end);

  always_comb begin
    nxt_busy = busy_q;
    nxt_k    = k_q;
    nxt_v    = v_q;
    nxt_vcnt = vcnt_q;
    nxt_hs   = hs_q;
    nxt_hbp  = hbp_q;
    nxt_hact = hact_q;
    nxt_hfp  = hfp_q;
    nxt_vs   = vs_q;
    nxt_vbp  = vbp_q;
    nxt_vact = vact_q;
    nxt_vfp  = vfp_q;
    if (start) begin
      nxt_busy = 1'b1;
      nxt_k    = '0;
      nxt_v    = V_SYNC;
      nxt_vcnt = '0;
      nxt_hs   = clamp_h(H_Sync_Len);
      nxt_hbp  = clamp_h(H_Back_Len);
      nxt_hact = clamp_h(H_Active_Len);
      nxt_hfp  = clamp_h(H_Front_Len);
      nxt_vs   = clamp_v(V_Sync_Len);
      nxt_vbp  = clamp_v(V_Back_Len);
      nxt_vact = clamp_v(V_Active_Len);
      nxt_vfp  = clamp_v(V_Front_Len);
    end else if (frame_end) begin
      nxt_busy = 1'b0;
      nxt_k    = '0;
      nxt_v    = V_SYNC;
      nxt_vcnt = '0;
    end else if (busy_q) begin
      if (line_end) begin
        nxt_k = '0;
        if (v_last) begin
          nxt_v    = v_q + 2'd1;
          nxt_vcnt = '0;
        end else begin
          nxt_vcnt = vcnt_q + V_WIDTH'(1);
        end
      end else begin
        nxt_k = k_q + KW'(1);
      end
    end
  end

  assign nxt_h   = (nxt_k < KW'(nxt_hs)) ? H_SYNC : H_LINE;
  assign bp_full = AW'(nxt_hbp) - AW'(1);
  assign fp_full = AW'(nxt_hbp) + AW'(nxt_hact);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy_q <= 1'b0;
      k_q    <= '0;
      v_q    <= V_SYNC;
      vcnt_q <= '0;
      hs_q   <= '0;
      hbp_q  <= '0;
      hact_q <= '0;
      hfp_q  <= '0;
      vs_q   <= '0;
      vbp_q  <= '0;
      vact_q <= '0;
      vfp_q  <= '0;
    end else begin
      busy_q <= nxt_busy;
      k_q    <= nxt_k;
      v_q    <= nxt_v;
      vcnt_q <= nxt_vcnt;
      hs_q   <= nxt_hs;
      hbp_q  <= nxt_hbp;
      hact_q <= nxt_hact;
      hfp_q  <= nxt_hfp;
      vs_q   <= nxt_vs;
      vbp_q  <= nxt_vbp;
      vact_q <= nxt_vact;
      vfp_q  <= nxt_vfp;
    end
  end

  // Outputs are registered from the next-state view so they line up with k and the vertical state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      HSync       <= 1'b1;
      VSync       <= 1'b1;
      Sync        <= 1'b0;
      BackPorch   <= '0;
      FrontPorch  <= '0;
      Line        <= '0;
      Frame_Start <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      Busy        <= nxt_busy;
      Frame_Start <= start;
      HSync       <= !(nxt_busy && (nxt_h == H_SYNC));
      VSync       <= !(nxt_busy && (nxt_v == V_SYNC));
      Sync        <= nxt_busy && (nxt_h == H_LINE) && (nxt_v == V_ACTIVE);
      Line        <= (nxt_busy && (nxt_v == V_ACTIVE)) ? nxt_vcnt : '0;
      if (start) begin
        BackPorch  <= BACKPORCH_WIDTH'(bp_full);
        FrontPorch <= FRONTPORCH_WIDTH'(fp_full);
      end else if (!nxt_busy) begin
        BackPorch  <= '0;
        FrontPorch <= '0;
      end
    end
  end

endmodule
